apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- Single-outstanding APB4 requester that converts a simple valid/ready command/response interface into APB SETUP/ACCESS transfers.
- Sits directly upstream of APB completer blocks such as the register-file template slave, and drives its paddr/psel/penable/pwrite/pwdata/pstrb/pprot inputs.
- Handles pready wait states, returns pslverr as a response error, and aborts hung transfers via a timeout.

Parameters:
- DATA_WIDTH, 32, APB data width; must be a multiple of 8.
- ADDR_WIDTH, 32, APB address width.
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles without pready before abort; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  transfer error (pslverr, timeout or misalignment).
- paddr  out  ADDR_WIDTH  APB address.
- pprot  out  3  APB protection.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- pready  in  1  completer ready.
- prdata  in  DATA_WIDTH  completer read data.
- pslverr  in  1  completer error.

Behaviour:
- Reset state: every output is 0, cmd_ready included. The FSM enters IDLE. The first rising edge after presetn deasserts leaves cmd_ready=1.
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid&&cmd_ready, capture addr, wdata, strb, prot and write. cmd_ready drops on the next edge.
  - Aligned address: go to SETUP.
  - Misaligned address (cmd_addr mod DATA_WIDTH/8 != 0): go straight to RESP with rsp_err=1 and rsp_rdata=0. No APB transfer is issued.
- SETUP:
  - Exactly one cycle: psel=1, penable=0.
  - paddr, pwrite, pprot, pwdata and pstrb are driven from the captured values. pstrb is forced to 0 on reads.
  - Always transitions to ACCESS.
- ACCESS:
  - psel=1, penable=1. All address, control and data outputs are held stable.
  - Completion occurs at the rising edge where pready=1. At that edge, capture rsp_err=pslverr and rsp_rdata = (read && !pslverr) ? prdata : 0. Then drop psel and penable and go to RESP.
  - A wait-cycle counter counts cycles with pready=0. If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, drop psel and penable, set rsp_err=1, rsp_rdata=0, and go to RESP.
  - pready arriving in the same cycle the timeout expires takes priority: the transfer completes normally.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
  - cmd_ready stays 0 throughout, so no new command is taken while a response is pending.
- Latency with zero wait states and rsp_ready=1:
  - Accept at edge N; SETUP in cycle N+1; ACCESS in cycle N+2; rsp_valid high in cycle N+3; cmd_ready high again in cycle N+4.
  - Throughput is one transfer per 4 cycles.
- Between transfers: psel=penable=0. paddr, pwdata and pwrite keep their last values; pstrb=0.
- Reset asserted mid-transfer: psel, penable, rsp_valid and cmd_ready go to 0 asynchronously. The in-flight command is dropped and no response is produced.
- pprot is passed through unmodified. The bridge performs no address-range check; range errors come only from pslverr.

Test Plan:
- Write 0xA5A50001 to 0x08 with pready=1 → psel high in cycle N+1, penable in N+2, rsp_valid with rsp_err=0 in N+3. A following read of 0x08 → rsp_rdata=0xA5A50001, pstrb=0 during the read.
- Completer holds pready low 3 cycles on a write to 0x0C → penable high 4 cycles; paddr=0x0C and pwdata stable throughout; rsp_err=0.
- Read of 0x04 against a completer with BASE_ADDR=8 that asserts pslverr → rsp_err=1, rsp_rdata=0. The next command is accepted normally.
- pready tied low, TIMEOUT_CYCLES=16 → psel drops after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0; cmd_ready returns after the response handshake.
- Command to 0x0A (misaligned) → psel never rises; rsp_valid next cycle with rsp_err=1.
- rsp_ready low 5 cycles with cmd_valid held → cmd_ready stays 0 and rsp_rdata stays stable. Separately, presetn pulsed low during ACCESS → psel and penable fall immediately and no rsp_valid is produced.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB4 requester driven by a valid/ready command/response pair.
// Every output is registered; next-state values are derived from the FSM's next state.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic                    pready,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pslverr
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic [SW-1:0]         pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  accept, misaligned, timeout, done, to_resp;

    assign accept     = state_q == IDLE && cmd_valid && cmd_ready_q;
    assign misaligned = (cmd_addr & ADDR_WIDTH'(SW - 1)) != '0;
    // the cycle that would expire the timeout still completes if pready is high
    assign timeout    = TIMEOUT_CYCLES > 0 && !pready && int'(cnt_q) == TIMEOUT_CYCLES - 1;
    assign done       = state_q == ACCESS && pready;
    assign to_resp    = state_d == RESP && state_q != RESP;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_rdata_q <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = misaligned ? RESP : SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready || timeout) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_d = state_d == IDLE;
        psel_d      = state_d == SETUP || state_d == ACCESS;
        penable_d   = state_d == ACCESS;
        rsp_valid_d = state_d == RESP;
        paddr_d     = state_d == SETUP ? cmd_addr  : paddr_q;
        pwdata_d    = state_d == SETUP ? cmd_wdata : pwdata_q;
        pwrite_d    = state_d == SETUP ? cmd_write : pwrite_q;
        pprot_d     = state_d == SETUP ? cmd_prot  : pprot_q;
        pstrb_d     = state_d == SETUP ? (cmd_write ? cmd_strb : '0) :
                      state_d == ACCESS ? pstrb_q : '0;
        rsp_err_d   = done ? pslverr : to_resp ? 1'b1 : rsp_err_q;
        rsp_rdata_d = done ? (!pwrite_q && !pslverr ? prdata : '0) : to_resp ? '0 : rsp_rdata_q;
        cnt_d       = state_q == ACCESS && !pready ? cnt_q + 1'b1 : '0;
    end

    assign cmd_ready = cmd_ready_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign pprot     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: scoreboard bench with a small APB completer model (BASE_ADDR=8, programmable waits/hang).
module tb_apb_master_bridge;
    logic        pclk = 1'b0, presetn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b1;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite, pready, pslverr;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;

    int          n_cmp = 0, n_bad = 0;
    int          wait_cfg = 0, wcnt = 0;
    bit          hang = 1'b0;
    logic [31:0] mem [16];
    logic [32:0] sbq [$];

    apb_master_bridge dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    assign pready  = psel && penable && !hang && wcnt >= wait_cfg;
    assign pslverr = pready && paddr < 32'h8;
    assign prdata  = mem[paddr[5:2]];

    always @(posedge pclk) begin
        wcnt <= (psel && penable && !pready) ? wcnt + 1 : 0;
        if (pready && pwrite && !pslverr)
            for (int b = 0; b < 4; b++)
                if (pstrb[b]) mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge pclk) begin
        if (presetn && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = sbq.pop_front();
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e[32]});
                check("rsp_rdata", rsp_rdata, e[31:0]);
            end
        end
    end

    // returns 1ns after the accepting edge, i.e. in the SETUP cycle
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [2:0] p, input logic [31:0] er, input logic ee, input bit push);
        int t = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        @(negedge pclk);
        while (!cmd_ready && t < 100) begin @(negedge pclk); t++; end
        if (t >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge pclk);
        if (push) sbq.push_back({ee, er});
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge pclk);
        while (!cmd_ready && t < 100) begin @(negedge pclk); t++; end
        if (t >= 100) check("idle_timeout", 32'd0, 32'd1);
        @(posedge pclk); #1;
    endtask

    initial begin
        int pe;
        bit stab, seen;
        logic [31:0] r, v;
        #2;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("rst_psel_rsp", {30'd0, psel, rsp_valid}, 0);
        check("rst_paddr", paddr, 0);
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b1;
        @(posedge pclk); #1;
        check("first_cmd_ready", {31'd0, cmd_ready}, 1);

        send(1, 32'h8, 32'hA5A50001, 4'hF, 3'b101, 32'h0, 0, 1);
        check("n1_psel_penable", {30'd0, psel, penable}, 32'b10);
        check("n1_paddr", paddr, 32'h8);
        check("n1_pwdata", pwdata, 32'hA5A50001);
        check("n1_pstrb_pprot", {25'd0, pstrb, pprot}, {25'd0, 4'hF, 3'b101});
        @(posedge pclk); #1;
        check("n2_psel_penable", {30'd0, psel, penable}, 32'b11);
        check("n2_rsp_valid", {31'd0, rsp_valid}, 0);
        @(posedge pclk); #1;
        check("n3_rsp_valid_psel", {30'd0, rsp_valid, psel}, 32'b10);
        @(posedge pclk); #1;
        check("n4_cmd_ready", {31'd0, cmd_ready}, 1);

        send(0, 32'h8, 32'h0, 4'hF, 3'b000, 32'hA5A50001, 0, 1);
        check("rd_pstrb", {28'd0, pstrb}, 0);
        check("rd_pwrite", {31'd0, pwrite}, 0);
        wait_idle();

        wait_cfg = 3;
        send(1, 32'hC, 32'h12345678, 4'hF, 3'b000, 32'h0, 0, 1);
        pe = 0; stab = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (penable) begin
                pe++;
                stab &= paddr == 32'hC && pwdata == 32'h12345678 && psel && pwrite;
            end
        end
        check("wait_penable_cycles", pe, 4);
        check("wait_stable", {31'd0, stab}, 1);
        wait_idle();
        wait_cfg = 0;

        send(0, 32'h4, 32'h0, 4'hF, 3'b000, 32'h0, 1, 1);
        wait_idle();
        send(0, 32'hC, 32'h0, 4'hF, 3'b000, 32'h12345678, 0, 1);
        wait_idle();

        hang = 1'b1;
        send(0, 32'h10, 32'h0, 4'hF, 3'b000, 32'h0, 1, 1);
        pe = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge pclk);
            if (penable) pe++;
        end
        check("timeout_access_cycles", pe, 16);
        wait_idle();
        hang = 1'b0;
        check("timeout_cmd_ready", {31'd0, cmd_ready}, 1);

        send(0, 32'hA, 32'h0, 4'hF, 3'b000, 32'h0, 1, 1);
        check("misalign_psel", {31'd0, psel}, 0);
        check("misalign_rsp_valid", {31'd0, rsp_valid}, 1);
        wait_idle();

        rsp_ready = 1'b0;
        send(0, 32'h8, 32'h0, 4'hF, 3'b000, 32'hA5A50001, 0, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hC;
        pe = 0;
        @(negedge pclk);
        while (!rsp_valid && pe < 20) begin @(negedge pclk); pe++; end
        r = rsp_rdata; stab = 1; seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            stab &= rsp_rdata == r && rsp_valid;
            seen |= cmd_ready;
        end
        check("hold_rdata", r, 32'hA5A50001);
        check("hold_stable", {31'd0, stab}, 1);
        check("hold_cmd_ready", {31'd0, seen}, 0);
        @(posedge pclk); #1;
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        wait_idle();

        wait_cfg = 5;
        send(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 0, 0);
        @(posedge pclk); #1;
        check("rst_pre_penable", {31'd0, penable}, 1);
        #2 presetn = 1'b0;
        #1;
        check("rst_mid_psel_penable", {30'd0, psel, penable}, 0);
        check("rst_mid_ready_valid", {30'd0, cmd_ready, rsp_valid}, 0);
        @(posedge pclk); #3 presetn = 1'b1;
        wait_cfg = 0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge pclk);
            seen |= rsp_valid;
        end
        check("rst_no_rsp", {31'd0, seen}, 0);
        check("rst_cmd_ready_back", {31'd0, cmd_ready}, 1);
        @(posedge pclk); #1;

        v = $urandom;
        send(1, 32'h20, v, 4'b0101, 3'b000, 32'h0, 0, 1);
        wait_idle();
        send(0, 32'h20, 32'h0, 4'hF, 3'b000, {8'h00, v[23:16], 8'h00, v[7:0]} | (mem[8] & 32'hFF00FF00), 0, 1);
        wait_idle();

        check("scoreboard_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
